harness_frame_controller: RTL
=============================

# harness_frame_controller

Frame sequencer inside the high-throughput test harness, between the UART receiver/transmitter byte streams and the accelerator under test. It splits the host's null-terminated RX byte stream into frames and feeds each frame to the accelerator input with `in_last` on the final payload byte. It forwards accelerator output bytes to the UART transmitter, then appends a 0x00 terminator. It also enforces a maximum frame length and an output watchdog.

## Interface
- `DATA_WIDTH`, 8: byte width on all streams.
- `MAX_FRAME_LENGTH`, 256: maximum payload bytes forwarded per frame (≥1).
- `TIMEOUT_CYCLES`, 1_000_000: idle output cycles tolerated after input is done.
- `clock  in  1`: sole clock.
- `reset  in  1`: asynchronous, active-low (0 = in reset).
- `rx_data  in  DATA_WIDTH`: byte from UART receiver.
- `rx_valid  in  1`, `rx_ready  out  1`: receiver handshake.
- `in_data  out  DATA_WIDTH`, `in_valid  out  1`, `in_last  out  1`, `in_ready  in  1`: accelerator input stream.
- `out_data  in  DATA_WIDTH`, `out_valid  in  1`, `out_last  in  1`, `out_ready  out  1`: accelerator output stream.
- `tx_data  out  DATA_WIDTH`, `tx_valid  out  1`, `tx_ready  in  1`: UART transmitter handshake.
- `busy  out  1`: state ≠ IDLE.
- `frame_done  out  1`: one-cycle pulse on terminator handshake.
- `frame_count  out  16`: completed frames, wraps.
- `error_overflow  out  1`, `error_timeout  out  1`: sticky until reset.

## Operation
- All handshakes are valid/ready. A transfer occurs on a rising `clock` when valid && ready. Valid is never withdrawn before its transfer.
- One-byte hold register (`hold_data`, `hold_valid`) plus payload counter `count`.
- Each held byte is released only once it is known whether it is the last byte:
  - `in_valid = hold_valid && !in_done && (rx_valid || count == MAX_FRAME_LENGTH)`
  - `in_last = (count == MAX_FRAME_LENGTH) || rx_data == 0x00`
- States:
  - IDLE: `rx_ready=1`.
    - Byte 0x00 → TERM. The accelerator is not touched.
    - Nonzero byte → hold it, `count=1`, clear `in_done`/`out_done`/`discard` → ACTIVE.
  - ACTIVE, input side:
    - `rx_ready = discard || (!in_done && (!hold_valid || in_ready))`.
    - On rx transfer with hold full:
      - The held byte transfers to the accelerator.
      - A nonzero rx byte loads the hold register and increments `count`.
      - A 0x00 rx byte clears the hold and sets `in_done`.
    - At `count == MAX_FRAME_LENGTH`, the held byte goes out with `in_last=1`. This sets `in_done` and `discard`.
    - While `discard` is set, rx bytes are consumed and dropped. Each dropped nonzero byte sets `error_overflow`. A 0x00 byte clears `discard`.
  - ACTIVE, output side (independent of the input side):
    - `tx_data = out_data`.
    - `tx_valid = out_valid && !out_done`.
    - `out_ready = tx_ready && !out_done`.
    - An `out_last` transfer sets `out_done`.
  - ACTIVE → TERM when `in_done && out_done && !discard`.
  - Watchdog: counts cycles while `in_done && !out_done`; reset on any out transfer. Reaching `TIMEOUT_CYCLES` sets `error_timeout` and forces → TERM. A pending `discard` continues in TERM/IDLE until the 0x00 terminator is consumed.
  - TERM: `tx_valid=1`, `tx_data=0x00`, `rx_ready=0` unless `discard`. On the tx transfer: pulse `frame_done`, increment `frame_count` → IDLE.
- Outside ACTIVE: `out_ready=1`. Stray accelerator output is dropped; `tx` carries only the TERM byte.

## Timing
- Reset values:
  - state IDLE.
  - `rx_ready=1`.
  - All valids, `in_last`, `busy`, `frame_done`, errors = 0.
  - `frame_count=0`, `tx_data=0`, hold empty.
- Async assert clears everything immediately, including mid-frame; a partially sent frame is abandoned. Deassertion is synchronised externally.
- Latency:
  - rx→in: the held byte is presented combinationally in the cycle the next rx byte is valid.
  - out→tx: combinational, zero cycles.
  - Terminator is offered the cycle after ACTIVE→TERM.
- `in_valid`/`in_last` depend combinationally on `rx_valid`/`rx_data`; `out_ready` depends on `tx_ready`. No registered loop back to rx/tx.
- Simultaneous `out_last` transfer and final `in_last` transfer in one cycle: TERM is entered on the next cycle.

## Structure
- Shared package `harness_pkg`: `FRAME_TERMINATOR = 8'h00`; state enum {IDLE, ACTIVE, TERM}.
- Sub-module `harness_watchdog`:
  - Ports: `clock`, `reset`, `enable`, `kick`, `expired`.
  - Counter width `$clog2(TIMEOUT_CYCLES+1)`; saturating.

## Test plan
- Echo accelerator model (`out` = `in`), send "ABC",0x00 → `in` sees A,B,C with `in_last` on C; tx emits 41,42,43,00; `frame_count=1`.
- Single 0x00 → no `in` transfer; tx emits 00 only; `frame_done` pulses once.
- `MAX_FRAME_LENGTH=4`, send "ABCDEF",0x00 → `in` sees A,B,C,D with last on D; E,F dropped; `error_overflow=1`; tx 41..44,00.
- Accelerator never asserts `out_valid`, `TIMEOUT_CYCLES=50` → `error_timeout` set 50 cycles after `in_last`; tx emits 00; next frame still processed.
- Random `in_ready`/`tx_ready` backpressure over 26-byte "ABCDEFGHI@ABCDABCDEFGHIJK",0x00 → byte order preserved, no loss or duplication.
- Assert `reset`=0 mid-frame after 3 bytes → all outputs at reset values within the same cycle; subsequent "AB",0x00 processes normally.

Source files
------------

// File: rtl/harness_pkg.sv
// Shared definitions for the harness frame sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package harness_pkg;

  localparam logic [7:0] FRAME_TERMINATOR = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TERM   = 2'd2
  } state_t;

endpackage

// File: rtl/harness_watchdog.sv
// Output watchdog: counts enabled cycles since the last kick, saturating.
// Latency: expired asserts combinationally in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; kick or a dropped enable clears the count.
module harness_watchdog #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT   = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Idle-cycle counter; restarts on activity, holds at the ceiling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!enable || kick) begin
      r_count <= '0;
    end else if (r_count != SAT) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Firing on the last tolerated cycle lets the owner react on that same edge.
  assign expired = enable && !kick && (r_count >= LIMIT);

endmodule

// File: rtl/harness_frame_controller.sv
// Splits the null-terminated RX stream into accelerator frames and returns output plus a 0x00 terminator.
// Latency: rx->in combinational once the following byte is visible; out->tx zero cycles; terminator one cycle after completion.
// Backpressure: rx stalls on in_ready (or in TERM); out stalls on tx_ready; overflow bytes are drained, not stalled.
module harness_frame_controller
  import harness_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int MAX_FRAME_LENGTH = 256,
  parameter int TIMEOUT_CYCLES   = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  output logic                  in_last,
  input  logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_valid,
  input  logic                  out_last,
  output logic                  out_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  error_overflow,
  output logic                  error_timeout
);

  localparam int CNT_W = $clog2(MAX_FRAME_LENGTH + 1);
  localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_FRAME_LENGTH);
  localparam logic [DATA_WIDTH-1:0] TERM_BYTE = DATA_WIDTH'(FRAME_TERMINATOR);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_valid;
  logic [CNT_W-1:0]      r_count;
  logic                  r_in_done;
  logic                  r_out_done;
  logic                  r_discard;
  logic                  r_frame_done;
  logic [15:0]           r_frame_count;
  logic                  r_err_ovf;
  logic                  r_err_to;

  logic w_active, w_at_max, w_rx_zero;
  logic w_rx_fire, w_in_fire, w_out_fire, w_tx_fire;
  logic w_in_end, w_out_end;
  logic w_in_done_nxt, w_out_done_nxt, w_discard_nxt;
  logic w_wd_enable, w_wd_kick, w_wd_expired;

  assign w_active  = (r_state == ACTIVE);
  assign w_at_max  = (r_count == MAX_CNT);
  assign w_rx_zero = (rx_data == TERM_BYTE);

  assign w_rx_fire  = rx_valid && rx_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_tx_fire  = tx_valid && tx_ready;

  // Completion is judged on next-state values so a simultaneous final in/out
  // transfer moves to TERM on that same edge.
  assign w_in_end       = w_in_fire && in_last;
  assign w_out_end      = w_active && w_out_fire && out_last;
  assign w_in_done_nxt  = r_in_done || w_in_end;
  assign w_out_done_nxt = r_out_done || w_out_end;
  assign w_discard_nxt  = r_discard ? !(w_rx_fire && w_rx_zero)
                                    : (w_in_fire && w_at_max && !(w_rx_fire && w_rx_zero));

  // Held byte goes out only once its successor (or the length cap) says whether it is last.
  assign in_data  = r_hold_data;
  assign in_valid = w_active && r_hold_valid && !r_in_done && (rx_valid || w_at_max);
  assign in_last  = in_valid && (w_at_max || w_rx_zero);

  // Outside ACTIVE the accelerator output is swallowed and tx carries only the terminator.
  assign out_ready = w_active ? (tx_ready && !r_out_done) : 1'b1;
  assign tx_valid  = (r_state == TERM) || (w_active && out_valid && !r_out_done);
  assign tx_data   = w_active ? out_data : TERM_BYTE;

  assign busy           = (r_state != IDLE);
  assign frame_done     = r_frame_done;
  assign frame_count    = r_frame_count;
  assign error_overflow = r_err_ovf;
  assign error_timeout  = r_err_to;

  assign w_wd_enable = w_active && r_in_done && !r_out_done;
  assign w_wd_kick   = w_active && w_out_fire;

  harness_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .enable (w_wd_enable),
    .kick   (w_wd_kick),
    .expired(w_wd_expired)
  );

  // RX acceptance: always in IDLE, only while draining in TERM.
  always_comb begin
    rx_ready = 1'b1;
    case (r_state)
      ACTIVE:  rx_ready = r_discard || (!r_in_done && (!r_hold_valid || in_ready));
      TERM:    rx_ready = r_discard;
      default: rx_ready = 1'b1;
    endcase
  end

  // Frame sequencer: hold register, length cap, overflow drain, terminator emission.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_hold_data   <= '0;
      r_hold_valid  <= 1'b0;
      r_count       <= '0;
      r_in_done     <= 1'b0;
      r_out_done    <= 1'b0;
      r_discard     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err_ovf     <= 1'b0;
      r_err_to      <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // Overflow drain survives state changes until the host's terminator arrives.
      if (r_discard && w_rx_fire) begin
        if (w_rx_zero) r_discard <= 1'b0;
        else           r_err_ovf <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!r_discard && w_rx_fire) begin
            if (w_rx_zero) begin
              r_state <= TERM;
            end else begin
              r_hold_data  <= rx_data;
              r_hold_valid <= 1'b1;
              r_count      <= CNT_W'(1);
              r_in_done    <= 1'b0;
              r_out_done   <= 1'b0;
              r_state      <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (w_in_fire) begin
            if (w_at_max) begin
              // Cap reached: a byte arriving alongside is already excess.
              r_hold_valid <= 1'b0;
              r_in_done    <= 1'b1;
              if (!(w_rx_fire && w_rx_zero)) r_discard <= 1'b1;
              if (w_rx_fire && !w_rx_zero)   r_err_ovf <= 1'b1;
            end else if (w_rx_zero) begin
              r_hold_valid <= 1'b0;
              r_in_done    <= 1'b1;
            end else begin
              r_hold_data <= rx_data;
              r_count     <= r_count + 1'b1;
            end
          end
          if (w_out_end) r_out_done <= 1'b1;
          if (w_wd_expired) begin
            r_err_to <= 1'b1;
            r_state  <= TERM;
          end else if (w_in_done_nxt && w_out_done_nxt && !w_discard_nxt) begin
            r_state <= TERM;
          end
        end
        TERM: begin
          if (w_tx_fire) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
